// File: rtl/sound_player_multi_pkg.sv
// sound_player_multi_pkg: shared FSM encodings and default tone tables for the multi-lane buzzer player.
package sound_player_multi_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int          DEF_DIV_W     = 20;
    localparam int          DEF_DUR_W     = 24;
    localparam logic [19:0] DEF_HIT_HALF  = 20'd50000;
    localparam logic [19:0] DEF_MISS_HALF = 20'd200000;
    localparam logic [23:0] DEF_DUR       = 24'd5000000;
    localparam logic [23:0] DEF_GAP       = 24'd500000;
endpackage

// File: rtl/sound_player_multi_tone_gen.sv
// tone_gen: half-period counter driving a square wave; held cleared while disabled.
module tone_gen #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] half,
    output logic             sq
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;

    // a zero half-period behaves as one so the wave never stalls
    assign lim = (half == '0) ? '0 : half - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (cnt >= lim) begin
            cnt <= '0;
            sq  <= ~sq;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sound_player_multi.sv
// sound_player_multi: per-lane hit / shared miss buzzer player with one-deep last-wins pending buffer, gap and mute.
module sound_player_multi
    import sound_player_multi_pkg::*;
#(
    parameter int                     LANES      = 4,
    parameter int                     DIV_W      = DEF_DIV_W,
    parameter logic [LANES*DIV_W-1:0] HIT_HALF   = {LANES{DIV_W'(DEF_HIT_HALF)}},
    parameter logic [DIV_W-1:0]       MISS_HALF  = DIV_W'(DEF_MISS_HALF),
    parameter int                     DUR_W      = DEF_DUR_W,
    parameter logic [DUR_W-1:0]       DUR_CYCLES = DUR_W'(DEF_DUR),
    parameter logic [DUR_W-1:0]       GAP_CYCLES = DUR_W'(DEF_GAP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] note_action,
    input  logic [LANES-1:0] note_success,
    input  logic             mute,
    output logic             buzzer_sound,
    output logic             busy,
    output logic [2:0]       tone_lane,
    output logic             tone_hit
);
    state_t           state, nxt;
    logic             ev_valid, ev_hit, eff_valid, eff_hit;
    logic             pend_valid, pend_hit, play_load;
    logic             mute_q, tone_end, gap_end, tone_en, sq;
    logic [2:0]       ev_lane, eff_lane, pend_lane;
    logic [DUR_W-1:0] dur_cnt, gap_cnt;
    logic [DIV_W-1:0] hit_tab [8];
    logic [DIV_W-1:0] half;

    for (genvar g = 0; g < 8; g++) begin : g_tab
        if (g < LANES) begin : g_on
            assign hit_tab[g] = HIT_HALF[g*DIV_W +: DIV_W];
        end else begin : g_off
            assign hit_tab[g] = DIV_W'(1);
        end
    end

    // descending scan leaves the lowest set lane as the winner
    always_comb begin
        ev_lane = '0;
        ev_hit  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (note_action[i]) begin
                ev_lane = 3'(i);
                ev_hit  = note_success[i];
            end
        end
    end

    assign ev_valid  = |note_action;
    assign eff_valid = ev_valid | pend_valid;
    assign eff_lane  = ev_valid ? ev_lane : pend_lane;
    assign eff_hit   = ev_valid ? ev_hit : pend_hit;
    assign tone_end  = dur_cnt == DUR_CYCLES - 1'b1;
    assign gap_end   = gap_cnt == GAP_CYCLES - 1'b1;

    always_comb begin
        nxt       = state;
        play_load = 1'b0;
        case (state)
            S_IDLE: begin
                nxt       = ev_valid ? S_PLAY : S_IDLE;
                play_load = ev_valid;
            end
            S_PLAY: begin
                if (tone_end) begin
                    nxt       = !eff_valid ? S_IDLE : (GAP_CYCLES == '0) ? S_PLAY : S_GAP;
                    play_load = eff_valid && (GAP_CYCLES == '0);
                end
            end
            S_GAP: begin
                nxt       = gap_end ? S_PLAY : S_GAP;
                play_load = gap_end;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mute_q     <= 1'b0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
            tone_lane  <= '0;
            tone_hit   <= 1'b0;
            pend_valid <= 1'b0;
            pend_lane  <= '0;
            pend_hit   <= 1'b0;
        end else begin
            state     <= nxt;
            mute_q    <= mute;
            dur_cnt   <= (nxt == S_PLAY && !play_load) ? dur_cnt + 1'b1 : '0;
            gap_cnt   <= (state == S_GAP && nxt == S_GAP) ? gap_cnt + 1'b1 : '0;
            tone_lane <= play_load ? eff_lane : (nxt == S_PLAY) ? tone_lane : '0;
            tone_hit  <= play_load ? eff_hit : (nxt == S_PLAY) && tone_hit;
            if (play_load) begin
                pend_valid <= 1'b0;
            end else if (ev_valid) begin
                pend_valid <= 1'b1;
                pend_lane  <= ev_lane;
                pend_hit   <= ev_hit;
            end
        end
    end

    // the square is cleared on the tone's last cycle so a back-to-back tone restarts in phase
    assign tone_en = (state == S_PLAY) && !tone_end;
    assign half    = tone_hit ? hit_tab[tone_lane] : MISS_HALF;

    tone_gen #(.DIV_W(DIV_W)) u_tone (
        .clk (clk),
        .rst (rst),
        .en  (tone_en),
        .half(half),
        .sq  (sq)
    );

    assign buzzer_sound = sq & ~mute_q & (state == S_PLAY);
    assign busy         = (state != S_IDLE) | pend_valid;
endmodule

// File: tb/tb_sound_player_multi.sv
// tb_sound_player_multi: directed stimulus with a per-cycle expected-output scoreboard.
module tb_sound_player_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] note_action, note_success;
    logic       mute;
    logic       buzzer_sound, busy, tone_hit;
    logic [2:0] tone_lane;

    typedef struct {
        int         tag;
        int         step;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step   = 0;

    always #5 clk = ~clk;

    sound_player_multi #(
        .LANES     (4),
        .DIV_W     (8),
        .HIT_HALF  ({8'd4, 8'd3, 8'd2, 8'd1}),
        .MISS_HALF (8'd5),
        .DUR_W     (8),
        .DUR_CYCLES(8'd20),
        .GAP_CYCLES(8'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .note_action (note_action),
        .note_success(note_success),
        .mute        (mute),
        .buzzer_sound(buzzer_sound),
        .busy        (busy),
        .tone_lane   (tone_lane),
        .tone_hit    (tone_hit)
    );

    // expected vector is {busy, tone_lane, tone_hit, buzzer_sound}
    task automatic push(input int tag, input logic b, input logic [2:0] l, input logic h, input logic z);
        exp_t e;
        e.tag  = tag;
        e.step = step;
        e.v    = {b, l, h, z};
        q.push_back(e);
        step++;
    endtask

    task automatic push_idle(input int tag, input int n);
        for (int k = 0; k < n; k++) push(tag, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic push_gap(input int tag);
        for (int k = 0; k < 4; k++) push(tag, 1'b1, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic push_tone(input int tag, input logic [2:0] l, input logic h, input int half,
                             input int n, input int mlo, input int mhi);
        for (int k = 0; k < n; k++)
            push(tag, 1'b1, l, h, ((k / half) % 2 == 1) && !(k >= mlo && k <= mhi));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] a, input logic [3:0] s);
        note_action  = a;
        note_success = s;
        tick(1);
        note_action  = '0;
        note_success = '0;
    endtask

    task automatic drain(input int tag);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain t%0d: %0d entries left, need 0", tag, q.size());
            q.delete();
        end
        #1;
    endtask

    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {busy, tone_lane, tone_hit, buzzer_sound};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL t%0d step %0d: got busy/lane/hit/buz=%b need %b", e.tag, e.step, got, e.v);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; note_action = '0; note_success = '0; mute = 1'b0;
        push_idle(0, 2);
        drain(0);
        rst = 1'b1;

        push_idle(1, 1); push_tone(1, 3'd0, 1'b1, 1, 20, 99, 99); push_idle(1, 2);
        pulse(4'b0001, 4'b0001);
        drain(1);

        push_idle(2, 1); push_tone(2, 3'd3, 1'b0, 5, 20, 99, 99); push_idle(2, 2);
        pulse(4'b1000, 4'b0000);
        drain(2);

        push_idle(3, 1); push_tone(3, 3'd1, 1'b1, 2, 20, 99, 99); push_idle(3, 3);
        pulse(4'b0110, 4'b0110);
        drain(3);

        push_idle(4, 1); push_tone(4, 3'd0, 1'b1, 1, 20, 99, 99); push_gap(4);
        push_tone(4, 3'd3, 1'b1, 4, 20, 99, 99); push_idle(4, 2);
        pulse(4'b0001, 4'b0001);
        tick(2);
        pulse(4'b0100, 4'b0100);
        tick(2);
        pulse(4'b1000, 4'b1000);
        drain(4);

        push_idle(5, 1); push_tone(5, 3'd0, 1'b1, 1, 20, 5, 9); push_idle(5, 2);
        pulse(4'b0001, 4'b0001);
        tick(4);
        mute = 1'b1;
        tick(5);
        mute = 1'b0;
        drain(5);

        push_idle(7, 1); push_tone(7, 3'd0, 1'b1, 1, 20, 99, 99); push_gap(7);
        push_tone(7, 3'd1, 1'b0, 5, 20, 99, 99); push_idle(7, 2);
        pulse(4'b0001, 4'b0001);
        tick(19);
        pulse(4'b0010, 4'b0000);
        drain(7);

        push_idle(6, 1); push_tone(6, 3'd1, 1'b1, 2, 5, 99, 99);
        pulse(4'b0010, 4'b0010);
        tick(1);
        pulse(4'b0100, 4'b0000);
        drain(6);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, tone_lane, tone_hit, buzzer_sound} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b need 000000", {busy, tone_lane, tone_hit, buzzer_sound});
        end
        push_idle(6, 3);
        tick(3);
        rst = 1'b1;
        push_idle(6, 30);
        drain(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
